// File: rtl/renode_ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed SRAM, with a fixed number of wait
// states per OKAY data phase and a two-cycle ERROR response for illegal transfers.
module renode_ahb_sram_subordinate #(
  parameter int                      AddressWidth  = 32,
  parameter int                      DataWidth     = 32,
  parameter int                      MemDepthWords = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress   = '0,
  parameter int                      WaitStates    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hsel,
  input  logic [AddressWidth-1:0] haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DataWidth-1:0]    hwdata,
  input  logic                    hready,
  output logic [DataWidth-1:0]    hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);

  localparam int Lanes   = DataWidth / 8;
  localparam int LaneW   = $clog2(Lanes);
  localparam int IdxW    = $clog2(MemDepthWords);
  localparam logic [AddressWidth:0] WinBytes = (AddressWidth+1)'(MemDepthWords * Lanes);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dp_valid_q, dp_write_q;
  logic [IdxW-1:0]   dp_idx_q;
  logic [LaneW-1:0]  dp_lane_q;
  logic [2:0]        dp_size_q;

  logic [DataWidth-1:0] mem [MemDepthWords];

  // Address-phase decode.
  logic [AddressWidth:0] offset;
  logic [6:0]            align_mask;
  logic                  req_err, accept, accept_ok;
  logic [IdxW-1:0]       req_idx;

  assign offset     = {1'b0, haddr} - {1'b0, BaseAddress};
  assign align_mask = (7'd1 << hsize) - 7'd1;
  assign req_err    = (offset >= WinBytes) || (hsize > 3'(LaneW)) || (|(haddr[6:0] & align_mask));
  assign accept     = hsel & hready & htrans[1];
  assign accept_ok  = accept & ~req_err;
  assign req_idx    = offset[LaneW +: IdxW];

  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state_q)
      S_WAIT: if (cnt_q != 4'd0) begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - 4'd1;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
    // A ready cycle ends the current data phase and may start the next one.
    if (hreadyout) begin
      if (accept && req_err) begin
        state_d = S_ERR1;
      end else if (accept_ok && (WaitStates > 0)) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WaitStates);
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_lane_q  <= '0;
      dp_size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hreadyout) begin
        dp_valid_q <= accept_ok;
        dp_write_q <= hwrite;
        dp_idx_q   <= req_idx;
        dp_lane_q  <= haddr[LaneW-1:0];
        dp_size_q  <= hsize;
      end
    end
  end

  // Data phase: byte enables, write commit, read launch.
  logic             commit, rd_load, rd_clear, bypass;
  logic [Lanes-1:0] be;
  logic [IdxW-1:0]  rd_idx;

  assign commit   = dp_valid_q & dp_write_q & hreadyout;
  assign rd_clear = accept & req_err & ~hwrite;
  assign bypass   = commit && (rd_idx == dp_idx_q);

  always_comb begin
    be = '0;
    for (int b = 0; b < Lanes; b++)
      be[b] = (b >= int'(dp_lane_q)) && (b < int'(dp_lane_q) + (1 << dp_size_q));
  end

  // Read data is registered on the edge that opens the completion cycle.
  always_comb begin
    if (WaitStates == 0) begin
      rd_load = accept_ok & ~hwrite;
      rd_idx  = req_idx;
    end else begin
      rd_load = (state_q == S_WAIT) && (cnt_q == 4'd1) && !dp_write_q;
      rd_idx  = dp_idx_q;
    end
  end

  // NOTE: the SRAM array has no reset; only control and output registers are reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < Lanes; b++)
        if (be[b]) mem[dp_idx_q][b*8 +: 8] <= hwdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrdata <= '0;
    end else if (rd_clear) begin
      hrdata <= '0;
    end else if (rd_load) begin
      for (int b = 0; b < Lanes; b++)
        hrdata[b*8 +: 8] <= (bypass && be[b]) ? hwdata[b*8 +: 8] : mem[rd_idx][b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_renode_ahb_sram_subordinate.sv
// Scoreboard bench: dut0 runs with zero wait states, dut1 with two; both share the clock.
module tb_renode_ahb_sram_subordinate;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          write;
    bit          err;
    int          waits;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic [1:0]       rst, hsel, hwrite;
  logic [1:0][31:0] haddr, hwdata;
  logic [1:0][1:0]  htrans;
  logic [1:0][2:0]  hsize, hburst;
  wire  [1:0]       hreadyout, hresp;
  wire  [1:0][31:0] hrdata;

  int tests_run = 0;
  int tests_failed = 0;
  req_t req_q[$];
  exp_t exp_q[$];
  logic [31:0] model [int];

  always #5 clk = ~clk;

  renode_ahb_sram_subordinate #(.WaitStates(0)) dut0 (
    .clk(clk), .rst(rst[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
    .hready(hreadyout[0]), .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0])
  );

  renode_ahb_sram_subordinate #(.WaitStates(2)) dut1 (
    .clk(clk), .rst(rst[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
    .hready(hreadyout[1]), .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1])
  );

  task automatic push_req(input bit write, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
    req_t r;
    r.write = write; r.addr = addr; r.size = size; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  // Reference model: window 0..0xFFF, 32-bit bus, little-endian lanes.
  task automatic predict(input int d, input req_t r, output exp_t e);
    int key;
    int lo;
    logic [31:0] w;
    e.write = r.write;
    e.addr  = r.addr;
    e.wdata = r.wdata;
    e.err   = (r.addr >= 32'h1000) || (r.size > 3'd2) ||
              ((r.addr & ((32'd1 << r.size) - 32'd1)) != 32'd0);
    e.waits = e.err ? 1 : (d == 0 ? 0 : 2);
    e.rdata = 32'h0;
    key = d * 65536 + int'(r.addr[11:2]);
    if (!e.err) begin
      if (r.write) begin
        w  = model.exists(key) ? model[key] : 32'h0;
        lo = int'(r.addr[1:0]);
        for (int b = 0; b < 4; b++)
          if (b >= lo && b < lo + (1 << r.size)) w[b*8 +: 8] = r.wdata[b*8 +: 8];
        model[key] = w;
      end else begin
        e.rdata = model[key];
      end
    end
  endtask

  // Drives queued requests as a pipelined stream; called just after a posedge.
  task automatic run(input int d, input string tag, output int cycles);
    req_t r;
    exp_t e;
    int   waits;
    bit   done;
    cycles = 0;
    waits  = 0;
    done   = 1'b0;
    for (int guard = 0; guard < 400 && !done; guard++) begin
      if (req_q.size() > 0) begin
        r = req_q[0];
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = r.addr;
        hwrite[d] = r.write; hsize[d] = r.size;
      end else begin
        hsel[d] = 1'b0; htrans[d] = 2'b00;
      end
      hwdata[d] = (exp_q.size() > 0 && exp_q[0].write) ? exp_q[0].wdata : 32'h0;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        cycles++;
        if (hreadyout[d]) begin
          e = exp_q.pop_front();
          tests_run++;
          if (hresp[d] !== e.err || waits != e.waits) begin
            tests_failed++;
            $display("FAIL %s @%h resp/waits: got resp=%b waits=%0d, expected resp=%b waits=%0d",
                     tag, e.addr, hresp[d], waits, e.err, e.waits);
          end
          if (!e.write) begin
            tests_run++;
            if (hrdata[d] !== e.rdata) begin
              tests_failed++;
              $display("FAIL %s @%h rdata: got %h, expected %h", tag, e.addr, hrdata[d], e.rdata);
            end
          end
          waits = 0;
        end else begin
          waits++;
          tests_run++;
          if (hresp[d] !== exp_q[0].err) begin
            tests_failed++;
            $display("FAIL %s @%h stall hresp: got %b, expected %b", tag, exp_q[0].addr,
                     hresp[d], exp_q[0].err);
          end
        end
      end
      if (hreadyout[d] && req_q.size() > 0) begin
        r = req_q.pop_front();
        predict(d, r, e);
        exp_q.push_back(e);
      end
      if (req_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: got %0d pending, expected 0", tag, req_q.size() + exp_q.size());
      req_q.delete();
      exp_q.delete();
    end
    hsel[d] = 1'b0;
    htrans[d] = 2'b00;
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests_run += 3;
      if (hreadyout[d] !== 1'b1) begin
        tests_failed++; $display("FAIL reset_hreadyout dut%0d: got %b, expected 1", d, hreadyout[d]);
      end
      if (hresp[d] !== 1'b0) begin
        tests_failed++; $display("FAIL reset_hresp dut%0d: got %b, expected 0", d, hresp[d]);
      end
      if (hrdata[d] !== 32'h0) begin
        tests_failed++; $display("FAIL reset_hrdata dut%0d: got %h, expected 0", d, hrdata[d]);
      end
    end
    @(posedge clk); #1;
    rst = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int c;
    push_req(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    push_req(1'b0, 32'h10, 3'd2, 32'h0);
    push_req(1'b1, 32'h14, 3'd2, 32'h13579BDF);
    push_req(1'b0, 32'h14, 3'd2, 32'h0);
    push_req(1'b0, 32'h10, 3'd2, 32'h0);
    run(0, "write_read", c);
    tests_run++;
    if (c != 5) begin
      tests_failed++; $display("FAIL write_read_cycles: got %0d, expected 5", c);
    end
  endtask

  task automatic test_byte_lanes;
    int c;
    push_req(1'b1, 32'h10, 3'd2, 32'h11223344);
    push_req(1'b1, 32'h13, 3'd0, 32'hAA5A5A5A);
    push_req(1'b0, 32'h10, 3'd2, 32'h0);
    push_req(1'b1, 32'h14, 3'd2, 32'h01020304);
    push_req(1'b1, 32'h16, 3'd1, 32'hBEEF1111);
    push_req(1'b0, 32'h14, 3'd2, 32'h0);
    push_req(1'b1, 32'h15, 3'd0, 32'h7777C377);
    push_req(1'b0, 32'h14, 3'd2, 32'h0);
    run(0, "byte_lanes", c);
  endtask

  task automatic test_wait_states;
    int c;
    for (int i = 0; i < 4; i++)
      push_req(1'b1, 32'(i * 4), 3'd2, 32'hC0DE0000 + 32'(i * 32'h111));
    run(1, "ws_fill", c);
    for (int i = 0; i < 4; i++) push_req(1'b0, 32'(i * 4), 3'd2, 32'h0);
    run(1, "ws_reads", c);
    tests_run++;
    if (c != 12) begin
      tests_failed++; $display("FAIL ws_back_to_back_cycles: got %0d, expected 12", c);
    end
  endtask

  task automatic test_errors;
    int c;
    push_req(1'b1, 32'h0,   3'd2, 32'h0BADF00D);
    push_req(1'b1, 32'hFFC, 3'd2, 32'h600DCAFE);
    push_req(1'b0, 32'hFFC, 3'd2, 32'h0);
    push_req(1'b0, 32'h1000, 3'd2, 32'h0);
    push_req(1'b0, 32'h10,  3'd2, 32'h0);
    push_req(1'b1, 32'h1,   3'd1, 32'hFFFFFFFF);
    push_req(1'b1, 32'h0,   3'd3, 32'hFFFFFFFF);
    push_req(1'b0, 32'h0,   3'd2, 32'h0);
    run(0, "errors_ws0", c);
    push_req(1'b0, 32'h1004, 3'd2, 32'h0);
    push_req(1'b1, 32'h2,   3'd2, 32'hFFFFFFFF);
    push_req(1'b0, 32'h0,   3'd2, 32'h0);
    run(1, "errors_ws2", c);
  endtask

  task automatic test_reset_mid_wait;
    int c;
    push_req(1'b1, 32'h20, 3'd2, 32'h12345678);
    run(1, "rst_prefill", c);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h20; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h55;
    tests_run++;
    if (hreadyout[1] !== 1'b0) begin
      tests_failed++; $display("FAIL rst_wait_entry hreadyout: got %b, expected 0", hreadyout[1]);
    end
    rst[1] = 1'b1;
    #1;
    tests_run += 3;
    if (hreadyout[1] !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid_hreadyout: got %b, expected 1", hreadyout[1]);
    end
    if (hresp[1] !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_hresp: got %b, expected 0", hresp[1]);
    end
    if (hrdata[1] !== 32'h0) begin
      tests_failed++; $display("FAIL rst_mid_hrdata: got %h, expected 0", hrdata[1]);
    end
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(posedge clk); #1;
    push_req(1'b0, 32'h20, 3'd2, 32'h0);
    run(1, "rst_readback", c);
  endtask

  initial begin
    rst = 2'b11; hsel = '0; hwrite = '0; haddr = '0; hwdata = '0;
    htrans = '0; hsize = '0; hburst = {3'b001, 3'b001};
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
